// File: rtl/serie_paralelo.sv
// Serial-to-parallel deserializer: rebuilds DATA_W-bit words from a strobed bit
// stream, flags truncated frames and keeps word/error statistics.
module serie_paralelo #(
  parameter int unsigned DATA_W    = 6,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              ser_in,
  input  logic              ser_ena,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_err,
  output logic              busy,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int unsigned    BCW  = $clog2(DATA_W + 1);
  localparam logic [BCW-1:0] LAST = BCW'(DATA_W);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] shifted;
  logic [BCW-1:0]    bcnt_q, bcnt_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  ecnt_q, ecnt_d;

  // The shift register is always zero in IDLE, so the same shifted value
  // serves both the first bit of a word and every following bit.
  always_comb begin
    if (MSB_FIRST) begin
      shifted = {shreg_q[DATA_W-2:0], ser_in};
    end else begin
      shifted = {ser_in, shreg_q[DATA_W-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    wcnt_d  = wcnt_q;
    ecnt_d  = ecnt_q;
    unique case (state_q)
      IDLE: begin
        if (ser_ena) begin
          shreg_d = shifted;
          bcnt_d  = BCW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_ena) begin
          if (bcnt_q == LAST - BCW'(1)) begin
            dout_d  = shifted;
            valid_d = 1'b1;
            wcnt_d  = wcnt_q + CNT_W'(1);
            shreg_d = '0;
            bcnt_d  = '0;
            state_d = IDLE;
          end else begin
            shreg_d = shifted;
            bcnt_d  = bcnt_q + BCW'(1);
          end
        end else begin
          ferr_d = 1'b1;
          if (ecnt_q != '1) begin
            ecnt_d = ecnt_q + CNT_W'(1);
          end
          shreg_d = '0;
          bcnt_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bcnt_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      wcnt_q  <= '0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      wcnt_q  <= wcnt_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q == SHIFT);
  assign word_cnt   = wcnt_q;
  assign err_cnt    = ecnt_q;

endmodule

// File: tb/tb_serie_paralelo.sv
// Bench for serie_paralelo: three instances (MSB-first, MSB-first with 2-bit
// counters, LSB-first) share one bit stream checked against a bit-queue model.
module tb_serie_paralelo;

  logic clk = 1'b0;
  logic clr, ser_in, ser_ena;

  logic [5:0]  dout_a, dout_b, dout_c;
  logic        val_a, val_b, val_c, ferr_a, ferr_b, ferr_c, busy_a, busy_b, busy_c;
  logic [15:0] wc_a, ec_a, wc_c, ec_c;
  logic [1:0]  wc_b, ec_b;

  always #5 clk = ~clk;

  serie_paralelo #(.DATA_W(6), .MSB_FIRST(1'b1), .CNT_W(16)) u_a (
    .clk(clk), .clr(clr), .ser_in(ser_in), .ser_ena(ser_ena),
    .data_out(dout_a), .data_valid(val_a), .frame_err(ferr_a), .busy(busy_a),
    .word_cnt(wc_a), .err_cnt(ec_a));

  serie_paralelo #(.DATA_W(6), .MSB_FIRST(1'b1), .CNT_W(2)) u_b (
    .clk(clk), .clr(clr), .ser_in(ser_in), .ser_ena(ser_ena),
    .data_out(dout_b), .data_valid(val_b), .frame_err(ferr_b), .busy(busy_b),
    .word_cnt(wc_b), .err_cnt(ec_b));

  serie_paralelo #(.DATA_W(6), .MSB_FIRST(1'b0), .CNT_W(16)) u_c (
    .clk(clk), .clr(clr), .ser_in(ser_in), .ser_ena(ser_ena),
    .data_out(dout_c), .data_valid(val_c), .frame_err(ferr_c), .busy(busy_c),
    .word_cnt(wc_c), .err_cnt(ec_c));

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model: received bits of the current word, in arrival order.
  int unsigned bq[$];
  int unsigned m_dout_msb, m_dout_lsb, m_wc, m_ec;
  logic        m_valid, m_ferr;

  int unsigned cyc = 0;
  int unsigned busy_cycles = 0;
  int unsigned valid_at[$];
  int unsigned ferr_seen = 0;
  bit          lb_on = 1'b0;
  int unsigned lb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    bq.delete();
    m_dout_msb = 0; m_dout_lsb = 0; m_wc = 0; m_ec = 0;
    m_valid = 1'b0; m_ferr = 1'b0;
  endtask

  task automatic model_edge(input logic e, input logic b);
    int unsigned wm, wl;
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    if (e) begin
      bq.push_back(int'(b));
      if (bq.size() == 6) begin
        wm = 0; wl = 0;
        for (int i = 0; i < 6; i++) begin
          wm = wm * 2 + bq[i];
          wl = wl + (bq[i] << i);
        end
        m_dout_msb = wm; m_dout_lsb = wl;
        m_valid = 1'b1;
        m_wc++;
        bq.delete();
      end
    end else if (bq.size() != 0) begin
      m_ferr = 1'b1;
      m_ec++;
      bq.delete();
    end
  endtask

  function automatic int unsigned sat(input int unsigned v, input int unsigned lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic check_all(input string tag);
    logic mbusy;
    mbusy = (bq.size() != 0);
    chk({tag, ":a.dout"},  32'(dout_a), m_dout_msb);
    chk({tag, ":b.dout"},  32'(dout_b), m_dout_msb);
    chk({tag, ":c.dout"},  32'(dout_c), m_dout_lsb);
    chk({tag, ":a.valid"}, 32'(val_a),  32'(m_valid));
    chk({tag, ":c.valid"}, 32'(val_c),  32'(m_valid));
    chk({tag, ":a.ferr"},  32'(ferr_a), 32'(m_ferr));
    chk({tag, ":c.ferr"},  32'(ferr_c), 32'(m_ferr));
    chk({tag, ":a.busy"},  32'(busy_a), 32'(mbusy));
    chk({tag, ":a.wc"},    32'(wc_a),   m_wc % 65536);
    chk({tag, ":b.wc"},    32'(wc_b),   m_wc % 4);
    chk({tag, ":a.ec"},    32'(ec_a),   sat(m_ec, 65535));
    chk({tag, ":b.ec"},    32'(ec_b),   sat(m_ec, 3));
  endtask

  // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
  task automatic step(input logic e, input logic b, input string tag);
    ser_ena = e;
    ser_in  = e ? b : 1'bx;
    @(posedge clk);
    model_edge(e, b);
    #1;
    cyc++;
    check_all(tag);
    if (busy_a) busy_cycles++;
    if (val_a) valid_at.push_back(cyc);
    if (ferr_a) ferr_seen++;
    if (lb_on && m_valid) chk("loopback_word", 32'(dout_a), lb_q.pop_front());
  endtask

  task automatic send_word(input logic [5:0] w, input int unsigned nbits, input string tag);
    for (int unsigned i = 0; i < nbits; i++) step(1'b1, w[5-i], tag);
  endtask

  // Called 1 unit after an edge; reset pulse lands between edges.
  task automatic arst(input string tag);
    #2 clr = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #2 clr = 1'b0;
  endtask

  int unsigned wc_exp[5] = '{1, 2, 3, 0, 1};
  int unsigned ec_exp[5] = '{3, 3, 3, 3, 3};
  int unsigned wc_before;
  logic [5:0]  w;

  initial begin
    clr = 1'b1; ser_ena = 1'b0; ser_in = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    clr = 1'b0;

    // Single MSB-first word 101101 = 6'h2D.
    busy_cycles = 0; valid_at.delete();
    send_word(6'h2D, 6, "single");
    chk("single_dout", 32'(dout_a), 32'h2D);
    chk("single_valid_pulses", valid_at.size(), 1);
    chk("single_busy_len", busy_cycles, 5);
    chk("single_lsb_dout", 32'(dout_c), 32'h2D);
    step(1'b0, 1'b0, "single_idle");
    chk("single_valid_dropped", 32'(val_a), 32'h0);

    // Back-to-back 3F then 00 with no gap.
    valid_at.delete(); ferr_seen = 0;
    send_word(6'h3F, 6, "b2b");
    chk("b2b_first", 32'(dout_a), 32'h3F);
    send_word(6'h00, 6, "b2b");
    chk("b2b_second", 32'(dout_a), 32'h00);
    chk("b2b_pulses", valid_at.size(), 2);
    if (valid_at.size() == 2) chk("b2b_spacing", valid_at[1] - valid_at[0], 6);
    chk("b2b_wc", 32'(wc_a), 3);
    chk("b2b_no_ferr", ferr_seen, 0);

    // Truncated frame, then a good word.
    send_word(6'h38, 3, "trunc");
    step(1'b0, 1'b0, "trunc_gap");
    chk("trunc_ferr", 32'(ferr_a), 1);
    chk("trunc_ec", 32'(ec_a), 1);
    chk("trunc_dout_held", 32'(dout_a), 32'h00);
    chk("trunc_busy", 32'(busy_a), 0);
    send_word(6'h15, 6, "after_trunc");
    chk("after_trunc_dout", 32'(dout_a), 32'h15);

    // Async reset in the middle of a word: no frame error afterwards.
    send_word(6'h2A, 4, "mid_word");
    arst("arst_mid");
    step(1'b0, 1'b0, "post_arst");
    chk("post_arst_no_ferr", 32'(ferr_a), 0);

    // Random bit stream with random gaps (mixes good and truncated frames).
    for (int i = 0; i < 600; i++) step(($urandom_range(0, 4) != 0), 1'($urandom), "random");

    // Counter limits on the CNT_W=2 instance.
    arst("arst_limits");
    for (int i = 0; i < 5; i++) begin
      send_word(6'($urandom), 6, "lim_word");
      chk("lim_wc_seq", 32'(wc_b), wc_exp[i]);
    end
    arst("arst_limits2");
    for (int i = 0; i < 5; i++) begin
      send_word(6'($urandom), $urandom_range(1, 5), "lim_err");
      step(1'b0, 1'b0, "lim_err_gap");
      chk("lim_ec_seq", 32'(ec_b), (i < 3) ? i + 1 : ec_exp[i]);
    end
    chk("lim_wide_ec", 32'(ec_a), 5);

    // Loopback: upstream serializer model sends 2000 random words MSB first.
    wc_before = m_wc;
    ferr_seen = 0;
    lb_on = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 5) != 0) step(1'b0, 1'b0, "lb_gap");
      w = 6'($urandom);
      lb_q.push_back(32'(w));
      send_word(w, 6, "lb");
    end
    step(1'b0, 1'b0, "lb_tail");
    lb_on = 1'b0;
    chk("lb_drained", lb_q.size(), 0);
    chk("lb_wc", 32'(wc_a), (wc_before + 2000) % 65536);
    chk("lb_no_ferr", ferr_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serie_paralelo.md
Name: serie_paralelo

Overview:
Serial-to-parallel deserializer placed directly downstream of the parallel-to-serial converter. It consumes that stage's serial bit stream (`out`) and its bit-valid strobe (`ena_out`), and rebuilds DATA_W-bit words. Each completed word is presented on a registered parallel bus with a one-cycle valid pulse. Truncated frames are discarded and flagged, and completed words and framing errors are counted for loopback checking against the serializer.

Parameters:
- DATA_W, 6: word width in bits; must be ≥ 2.
- MSB_FIRST, 1: 1 means the first serial bit received is data_out[DATA_W-1]; 0 means the first bit is data_out[0].
- CNT_W, 16: width of the word_cnt and err_cnt statistics counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  asynchronous, active-high reset.
- ser_in  in  1  serial data bit; sampled only when ser_ena=1.
- ser_ena  in  1  bit-valid strobe; one bit per cycle while high.
- data_out  out  DATA_W  last completed word; held until the next word completes.
- data_valid  out  1  one-cycle pulse when data_out is updated.
- frame_err  out  1  one-cycle pulse when a partial word is discarded.
- busy  out  1  high while a word is being assembled (state SHIFT).
- word_cnt  out  CNT_W  number of completed words; wraps modulo 2^CNT_W.
- err_cnt  out  CNT_W  number of framing errors; saturates at all-ones.

Behaviour:
- Reset (clr=1, asynchronous): state=IDLE, shift register=0, bit counter=0, data_out=0, data_valid=0, frame_err=0, busy=0, word_cnt=0, err_cnt=0. Deasserting clr takes effect at the next rising edge.
- Reset mid-word discards the partial word without raising frame_err.
- The FSM has two states, IDLE and SHIFT. The bit counter is ceil(log2(DATA_W+1)) bits wide.
- IDLE, ser_ena=1: sample ser_in into the shift register, counter=1, go to SHIFT.
  - If DATA_W bits have been collected, the word is complete; this cannot occur from IDLE since DATA_W ≥ 2.
- IDLE, ser_ena=0: stay in IDLE; no output activity.
- SHIFT, ser_ena=1: shift in ser_in, counter+1.
  - When the counter reaches DATA_W on this edge: load data_out with the assembled word, pulse data_valid, increment word_cnt, counter=0, go to IDLE.
- SHIFT, ser_ena=0 (gap before DATA_W bits): pulse frame_err, increment err_cnt (saturating), clear the shift register and counter, go to IDLE. data_out keeps its previous value.
- Back-to-back words: if ser_ena stays high past the completing bit, the next bit is sampled in IDLE on the following cycle. There are no dead cycles, so continuous streaming of one word per DATA_W cycles is supported.
- Shift direction:
  - MSB_FIRST=1: shift left, new bit into bit 0.
  - MSB_FIRST=0: shift right, new bit into bit DATA_W-1.
- Latency: data_valid and the new data_out are visible in the cycle immediately after the edge that samples the last bit. That is one clock after the last ser_ena cycle.
- data_valid and frame_err are never high in the same cycle. Each is high for exactly one cycle per event.
- busy = (state == SHIFT); it is registered, not combinational from the inputs.
- ser_in is don't-care when ser_ena=0; X on ser_in must not propagate in that case.
- No backpressure: the consumer must take data_out within DATA_W cycles of data_valid.

Test Plan:
- Reset: assert clr mid-simulation, asynchronously between edges → all outputs 0 immediately; word_cnt=0, err_cnt=0.
- Single word, MSB_FIRST=1, DATA_W=6: ser_ena high for 6 cycles with bits 1,0,1,1,0,1 → data_out=6'h2D one cycle after the 6th bit, data_valid high exactly 1 cycle, word_cnt=1, busy high for 5 cycles.
- Back-to-back streaming: ser_ena held high for 12 cycles carrying 6'h3F then 6'h00 → two data_valid pulses 6 cycles apart, data_out=3F then 00, word_cnt=2, no frame_err.
- Truncated frame: 3 bits (1,1,1), then ser_ena=0 → frame_err pulse on the next cycle, err_cnt=1, data_out unchanged (previous 6'h00), busy low. A following full word 6'h15 decodes correctly.
- Loopback: connect the upstream paraleloSerie stage with 2000 random 6-bit words, ena_in pattern 1 cycle low / 5 cycles high → every data_out equals the corresponding input word, word_cnt=2000, err_cnt=0.
- Counter limits with CNT_W=2: 5 completed words → word_cnt sequence 1,2,3,0,1; 5 truncated frames → err_cnt sticks at 3.
